// File: rtl/avmm_rd_pkg.sv
// Shared types and default parameters for the Avalon-MM burst read master.
package avmm_rd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        FINISH
    } state_e;

    localparam int DEF_DATA_W      = 32;
    localparam int DEF_ADDR_W      = 32;
    localparam int DEF_LEN_W       = 8;
    localparam int DEF_FIFO_DEPTH  = 4;
    localparam int DEF_TIMEOUT_CYC = 1024;

endpackage

// File: rtl/avmm_read_master_rd_fifo.sv
// Synchronous first-word-fall-through FIFO (module rd_fifo) buffering read responses.
module rd_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: storage is not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end

    assign count    = wr_ptr_q - rd_ptr_q;
    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/avmm_read_master.sv
// Avalon-MM burst read master streaming words out through a credit-limited FIFO.
// Optional stall timeout enabled by defining AVMM_RD_TIMEOUT_EN.
module avmm_read_master
    import avmm_rd_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int LEN_W       = DEF_LEN_W,
    parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [LEN_W-1:0]    len,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [ADDR_W-1:0]   avm_address,
    output logic                avm_read,
    output logic [DATA_W/8-1:0] avm_byteenable,
    input  logic                avm_waitrequest,
    input  logic [DATA_W-1:0]   avm_readdata,
    input  logic                avm_readdatavalid,
    output logic [DATA_W-1:0]   out_data,
    output logic                out_valid,
    input  logic                out_ready
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_W-1:0] ADDR_STEP  = ADDR_W'(DATA_W / 8);
    localparam logic [LEN_W:0]    LEN_ONE    = (LEN_W+1)'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W:0]    CREDIT_MAX = (CNT_W+1)'(FIFO_DEPTH);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W:0]    len_q, len_d;
    logic [LEN_W:0]    issued_q, issued_d;
    logic [LEN_W:0]    popped_q, popped_d;
    logic [CNT_W-1:0]  outst_q, outst_d;
    logic              read_q, read_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              accept, push, pop, timeout;
    logic [CNT_W-1:0]  fifo_count, fifo_next;
    logic              fifo_full, fifo_empty;
    logic [CNT_W:0]    credit_next;

    assign accept = read_q & ~avm_waitrequest;
    // Responses are only taken while a transfer owns them; stale ones after reset drop here.
    assign push   = avm_readdatavalid & (state_q != IDLE) & (outst_q != '0);
    assign pop    = ~fifo_empty & out_ready;

    rd_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (timeout),
        .push      (push),
        .push_data (avm_readdata),
        .pop       (pop),
        .pop_data  (out_data),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

`ifdef AVMM_RD_TIMEOUT_EN
    localparam int STALL_W = $clog2(TIMEOUT_CYC + 1);

    logic [STALL_W-1:0] stall_q, stall_d;
    logic               stalled;
    logic               error_q, error_d;

    assign stalled = (read_q & avm_waitrequest) | ((outst_q != '0) & ~avm_readdatavalid);
    assign timeout = stalled && (stall_q == STALL_W'(TIMEOUT_CYC - 1));

    always_comb begin
        stall_d = (stalled && !timeout) ? stall_q + STALL_W'(1) : '0;
        error_d = error_q;
        if (timeout)                       error_d = 1'b1;
        else if (state_q == IDLE && start) error_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            error_q <= 1'b0;
        end else begin
            stall_q <= stall_d;
            error_q <= error_d;
        end
    end

    assign error = error_q;
`else
    assign timeout = 1'b0;
    assign error   = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        len_d    = len_q;
        issued_d = issued_q;
        popped_d = popped_q;
        outst_d  = outst_q + (accept ? CNT_ONE : '0) - (push ? CNT_ONE : '0);
        done_d   = (state_q == FINISH);

        if (pop) popped_d = popped_q + LEN_ONE;

        case (state_q)
            IDLE: begin
                if (start) begin
                    issued_d = '0;
                    popped_d = '0;
                    if (len != '0) begin
                        state_d = ISSUE;
                        addr_d  = base_addr;
                        len_d   = {1'b0, len};
                    end else begin
                        state_d = FINISH;
                    end
                end
            end
            ISSUE: begin
                if (accept) begin
                    addr_d   = addr_q + ADDR_STEP;
                    issued_d = issued_q + LEN_ONE;
                    if (issued_d == len_q) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && popped_d == len_q) state_d = FINISH;
            end
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (timeout) begin
            state_d = FINISH;
            outst_d = '0;
        end

        fifo_next = fifo_count;
        if (push) fifo_next = fifo_next + CNT_ONE;
        if (pop)  fifo_next = fifo_next - CNT_ONE;
        if (timeout) fifo_next = '0;

        // Credit is judged on next-cycle occupancy so the registered request never overbooks the FIFO.
        credit_next = {1'b0, outst_d} + {1'b0, fifo_next};
        read_d = (state_d == ISSUE) && (credit_next < CREDIT_MAX);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            len_q    <= '0;
            issued_q <= '0;
            popped_q <= '0;
            outst_q  <= '0;
            read_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            issued_q <= issued_d;
            popped_q <= popped_d;
            outst_q  <= outst_d;
            read_q   <= read_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign avm_read       = read_q;
    assign avm_address    = addr_q;
    assign avm_byteenable = '1;
    assign out_valid      = ~fifo_empty;

endmodule

// File: tb/tb_avmm_read_master.sv
// Directed bench for avmm_read_master with a latency-programmable Avalon-MM slave model.
module tb_avmm_read_master;

    logic        clk = 1'b0;
    logic        rst_n, start, busy, done, error;
    logic [31:0] base_addr, avm_address, avm_readdata, out_data;
    logic [7:0]  len;
    logic        avm_read, avm_waitrequest, avm_readdatavalid, out_valid, out_ready;
    logic [3:0]  avm_byteenable;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    avmm_read_master #(
        .DATA_W(32), .ADDR_W(32), .LEN_W(8), .FIFO_DEPTH(4), .TIMEOUT_CYC(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .len(len),
        .busy(busy), .done(done), .error(error),
        .avm_address(avm_address), .avm_read(avm_read), .avm_byteenable(avm_byteenable),
        .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
        .avm_readdatavalid(avm_readdatavalid),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
    );

    function automatic logic [31:0] rdata_of(input logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ 32'h1357_0000;
    endfunction

    // Slave model: drives waitrequest/readdatavalid at the falling edge.
    typedef struct { int due; logic [31:0] addr; } pend_t;
    pend_t pend[$];
    int    lat = 2, acc_idx = 0, stall_idx = -1, stall_left = 0;
    bit    drop = 1'b0;

    always @(negedge clk) begin
        avm_waitrequest = 1'b0;
        if (avm_read && acc_idx == stall_idx && stall_left > 0) begin
            avm_waitrequest = 1'b1;
            stall_left--;
        end else if (avm_read) begin
            if (!drop) pend.push_back('{cyc + lat, avm_address});
            acc_idx++;
        end
        avm_readdatavalid = 1'b0;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            avm_readdatavalid = 1'b1;
            avm_readdata      = rdata_of(pend[0].addr);
            void'(pend.pop_front());
        end
    end

    // Monitor: samples 2 time units after the falling edge, well away from the active edge.
    logic [31:0] acc_q[$], got_q[$];
    logic [31:0] stall_addr, prev_addr;
    int  done_cnt, done_cyc, valid_cycles, stall_cycles, stall_bad, err_cyc, s_cyc;
    bit  prev_wait, err_seen;

    always @(negedge clk) begin
        #2;
        if (avm_read && !avm_waitrequest) acc_q.push_back(avm_address);
        if (prev_wait && (!avm_read || avm_address != prev_addr)) stall_bad++;
        if (avm_read && avm_waitrequest) begin
            stall_cycles++;
            stall_addr = avm_address;
        end
        prev_wait = avm_read && avm_waitrequest;
        prev_addr = avm_address;
        if (out_valid && out_ready) got_q.push_back(out_data);
        if (out_valid) valid_cycles++;
        if (done) begin done_cnt++; done_cyc = cyc; end
        if (error && !err_seen) begin err_seen = 1'b1; err_cyc = cyc; end
    end

    task automatic clear_mon();
        acc_q.delete(); got_q.delete();
        done_cnt = 0; valid_cycles = 0; stall_cycles = 0; stall_bad = 0;
        prev_wait = 1'b0; err_seen = 1'b0; acc_idx = 0;
    endtask

    task automatic pulse_start(input logic [31:0] b, input logic [7:0] l);
        @(negedge clk);
        start = 1'b1; base_addr = b; len = l; s_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        total++;
        if (done_cnt == 0) begin
            bad++;
            $display("FAIL %s_done_timeout got done_cnt=%0d want >=1 within %0d cycles", name, done_cnt, budget);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; base_addr = '0; len = '0; out_ready = 1'b1;
        avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0; avm_readdata = '0;
        #1;
        total++; if ({busy, done, error, avm_read, out_valid} !== 5'b0) begin
            bad++; $display("FAIL reset_outputs got=%b want=00000", {busy, done, error, avm_read, out_valid});
        end
        total++; if (avm_byteenable !== 4'hF) begin
            bad++; $display("FAIL reset_byteenable got=%h want=f", avm_byteenable);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy got=%b want=0", busy); end
    endtask

    task automatic test_basic();
        clear_mon(); lat = 2; drop = 1'b0; out_ready = 1'b1;
        pulse_start(32'h100, 8'd4);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy got=%b want=1", busy); end
        wait_done("basic", 100);
        total++; if (acc_q.size() != 4 || got_q.size() != 4) begin
            bad++; $display("FAIL basic_counts got reads=%0d words=%0d want 4/4", acc_q.size(), got_q.size());
        end
        for (int i = 0; i < 4 && i < acc_q.size() && i < got_q.size(); i++) begin
            total++; if (acc_q[i] !== 32'h100 + 32'(4 * i) || got_q[i] !== rdata_of(32'h100 + 32'(4 * i))) begin
                bad++; $display("FAIL basic_word%0d got addr=%h data=%h want addr=%h data=%h", i, acc_q[i],
                                got_q[i], 32'h100 + 32'(4 * i), rdata_of(32'h100 + 32'(4 * i)));
            end
        end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL basic_done_once got=%0d want=1", done_cnt); end
    endtask

    task automatic test_zero_len();
        clear_mon();
        pulse_start(32'h400, 8'd0);
        repeat (4) @(negedge clk);
        total++; if (done_cnt != 1 || done_cyc - s_cyc != 2) begin
            bad++; $display("FAIL zero_len_done got cnt=%0d delay=%0d want 1/2", done_cnt, done_cyc - s_cyc);
        end
        total++; if (acc_q.size() != 0) begin bad++; $display("FAIL zero_len_reads got=%0d want=0", acc_q.size()); end
    endtask

    task automatic test_backpressure();
        clear_mon(); out_ready = 1'b0;
        pulse_start(32'h2000, 8'd8);
        repeat (20) @(negedge clk);
        total++; if (acc_q.size() != 4) begin
            bad++; $display("FAIL bp_credit got reads=%0d want=4", acc_q.size());
        end
        out_ready = 1'b1;
        wait_done("bp", 100);
        total++; if (got_q.size() != 8) begin bad++; $display("FAIL bp_words got=%0d want=8", got_q.size()); end
        for (int i = 0; i < 8 && i < got_q.size(); i++) begin
            total++; if (got_q[i] !== rdata_of(32'h2000 + 32'(4 * i))) begin
                bad++; $display("FAIL bp_word%0d got=%h want=%h", i, got_q[i], rdata_of(32'h2000 + 32'(4 * i)));
            end
        end
    endtask

    task automatic test_waitrequest();
        clear_mon(); stall_idx = 1; stall_left = 5;
        pulse_start(32'h100, 8'd3);
        repeat (2) @(negedge clk);
        start = 1'b1; base_addr = 32'h900; len = 8'd1;
        @(negedge clk);
        start = 1'b0;
        wait_done("wait", 100);
        stall_idx = -1;
        total++; if (stall_cycles != 5 || stall_bad != 0 || stall_addr !== 32'h104) begin
            bad++; $display("FAIL wait_hold got cycles=%0d unstable=%0d addr=%h want 5/0/00000104",
                            stall_cycles, stall_bad, stall_addr);
        end
        total++; if (acc_q.size() != 3 || got_q.size() != 3) begin
            bad++; $display("FAIL wait_counts got reads=%0d words=%0d want 3/3", acc_q.size(), got_q.size());
        end
        total++; if (acc_q.size() == 3 && acc_q[2] !== 32'h108) begin
            bad++; $display("FAIL wait_last_addr got=%h want=00000108", acc_q[2]);
        end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL wait_done_once got=%0d want=1", done_cnt); end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_a[4];
        exp_a = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
        clear_mon();
        pulse_start(32'hFFFF_FFF8, 8'd4);
        wait_done("wrap", 100);
        total++; if (acc_q.size() != 4) begin bad++; $display("FAIL wrap_reads got=%0d want=4", acc_q.size()); end
        for (int i = 0; i < 4 && i < acc_q.size(); i++) begin
            total++; if (acc_q[i] !== exp_a[i]) begin
                bad++; $display("FAIL wrap_addr%0d got=%h want=%h", i, acc_q[i], exp_a[i]);
            end
        end
    endtask

    task automatic test_max_len();
        clear_mon();
        pulse_start(32'h1_0000, 8'd255);
        wait_done("maxlen", 2000);
        total++; if (got_q.size() != 255 || done_cnt != 1) begin
            bad++; $display("FAIL maxlen_counts got words=%0d done=%0d want 255/1", got_q.size(), done_cnt);
        end
        total++; if (got_q.size() == 255 && got_q[254] !== rdata_of(32'h1_0000 + 32'd1016)) begin
            bad++; $display("FAIL maxlen_last got=%h want=%h", got_q[254], rdata_of(32'h1_0000 + 32'd1016));
        end
    endtask

    task automatic test_reset_mid();
        clear_mon(); out_ready = 1'b0; lat = 2;
        pulse_start(32'h300, 8'd2);
        repeat (8) @(negedge clk);
        total++; if (out_valid !== 1'b1 || busy !== 1'b1) begin
            bad++; $display("FAIL rstmid_buffered got valid=%b busy=%b want 1/1", out_valid, busy);
        end
        #3 rst_n = 1'b0;
        #1;
        total++; if ({out_valid, busy, avm_read, done} !== 4'b0) begin
            bad++; $display("FAIL rstmid_async got=%b want=0000", {out_valid, busy, avm_read, done});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        clear_mon(); lat = 8;
        pulse_start(32'h500, 8'd2);
        repeat (3) @(negedge clk);
        #3 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        clear_mon();
        repeat (15) @(negedge clk);
        total++; if (valid_cycles != 0 || got_q.size() != 0 || busy !== 1'b0) begin
            bad++; $display("FAIL rstmid_late got valid_cycles=%0d words=%0d busy=%b want 0/0/0",
                            valid_cycles, got_q.size(), busy);
        end
        total++; if (pend.size() != 0) begin
            bad++; $display("FAIL rstmid_late_sent got pending=%0d want=0", pend.size());
        end
        lat = 2;
    endtask

`ifdef AVMM_RD_TIMEOUT_EN
    task automatic test_timeout();
        clear_mon(); drop = 1'b1;
        pulse_start(32'h700, 8'd2);
        wait_done("timeout", 60);
        drop = 1'b0;
        total++; if (!err_seen || err_cyc - s_cyc != 18 || done_cyc - s_cyc != 19) begin
            bad++; $display("FAIL timeout_timing got err=%0b err_dly=%0d done_dly=%0d want 1/18/19",
                            err_seen, err_cyc - s_cyc, done_cyc - s_cyc);
        end
        total++; if (error !== 1'b1 || out_valid !== 1'b0) begin
            bad++; $display("FAIL timeout_sticky got error=%b valid=%b want 1/0", error, out_valid);
        end
        pulse_start(32'h0, 8'd0);
        total++; if (error !== 1'b0) begin bad++; $display("FAIL timeout_clear got=%b want=0", error); end
        repeat (3) @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_zero_len();
        test_backpressure();
        test_waitrequest();
        test_wrap();
        test_max_len();
        test_reset_mid();
`ifdef AVMM_RD_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
